// File: rtl/apb_mem_pkg.sv
// Shared types, constants and sizing helpers for the APB memory bank.
package apb_mem_pkg;

  // Width of the latency down-counter; covers latencies 1..7.
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Number of DATA_W-wide words in a bank of size_k KiB.
  function automatic int mem_depth(input int size_k, input int data_w);
    return (size_k * 1024) / (data_w / 8);
  endfunction

  // Bits needed to index depth words (at least 1).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Byte-offset bits dropped from a byte address to form a word address.
  function automatic int off_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_mem_bank_if.sv
// Request/response bus between a requester and the memory bank.
interface apb_mem_bank_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic                  mem_req_i;
  logic [ADDR_W-1:0]     mem_addr_i;
  logic                  mem_we_i;
  logic [DATA_W-1:0]     mem_wdata_i;
  logic [DATA_W/8-1:0]   mem_wstrb_i;
  logic [DATA_W-1:0]     mem_rdata_o;
  logic                  mem_rdata_valid_o;
  logic                  busy_o;

  modport master (
    output mem_req_i, mem_addr_i, mem_we_i, mem_wdata_i, mem_wstrb_i,
    input  mem_rdata_o, mem_rdata_valid_o, busy_o
  );

  modport slave (
    input  mem_req_i, mem_addr_i, mem_we_i, mem_wdata_i, mem_wstrb_i,
    output mem_rdata_o, mem_rdata_valid_o, busy_o
  );

endinterface

// File: rtl/byte_strb_ram.sv
// Single-port array with per-byte write strobes and a registered read port.
// The read register only updates on an enabled read, so it holds the
// captured word for as long as the response takes. Storage has no reset.
module byte_strb_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192,
  parameter int IDX_W  = 13
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Select the next read-register value: new word on a read, else hold.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem_q[idx];
    end
  end

  // Commit strobed byte lanes and update the read register.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_mem_bank.sv
// Memory bank with fixed read/write response latencies.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for mem_req_i; the access is accepted on this edge
//   ST_WAIT  | latency counter running down toward the response
//   ST_RESP  | one-cycle completion pulse, read data presented
//   ST_DRAIN | completion given, waiting for the requester to drop req
//
// Writes commit and reads capture at the accept edge, so later changes on
// the request inputs have no effect and a request dropped mid-WAIT still
// completes.
module apb_mem_bank
  import apb_mem_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 64,
  parameter int              MEM_SIZE_K = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              RD_LAT     = 2,
  parameter int              WR_LAT     = 1
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb_mem_bank_if.slave bus
);

  localparam int DEPTH = mem_depth(MEM_SIZE_K, DATA_W);
  localparam int IDX_W = idx_width(DEPTH);
  localparam int OFF_W = off_width(DATA_W);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               resp_we_q, resp_we_d;

  logic               accept;
  logic [LAT_W-1:0]   lat_sel;
  logic [ADDR_W-1:0]  addr_off;
  logic [IDX_W-1:0]   word_idx;
  logic [DATA_W-1:0]  ram_rdata;

  // Out-of-range addresses simply wrap: keep the low index bits only.
  assign addr_off = bus.mem_addr_i - BASE_ADDR;
  assign word_idx = IDX_W'(addr_off >> OFF_W);

  // Reset wins over a coincident request, so nothing is committed then.
  assign accept  = (state_q == ST_IDLE) && bus.mem_req_i && !PRESET;
  assign lat_sel = bus.mem_we_i ? LAT_W'(WR_LAT) : LAT_W'(RD_LAT);

  byte_strb_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (PCLK),
    .en    (accept),
    .we    (bus.mem_we_i),
    .idx   (word_idx),
    .wdata (bus.mem_wdata_i),
    .wstrb (bus.mem_wstrb_i),
    .rdata (ram_rdata)
  );

  // State, counter and response-type registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      resp_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      resp_we_q <= resp_we_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resp_we_d = resp_we_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_req_i) begin
          resp_we_d = bus.mem_we_i;
          if (lat_sel <= LAT_W'(1)) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = lat_sel - LAT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= LAT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = bus.mem_req_i ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (!bus.mem_req_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state; read data is zero outside a read response.
  always_comb begin
    bus.mem_rdata_valid_o = (state_q == ST_RESP);
    bus.busy_o            = (state_q != ST_IDLE);
    bus.mem_rdata_o       = '0;
    if ((state_q == ST_RESP) && !resp_we_q) begin
      bus.mem_rdata_o = ram_rdata;
    end
  end

endmodule

// File: tb/tb_apb_mem_bank.sv
// Directed bench for apb_mem_bank: instance A uses default latencies,
// instance B uses a read latency of 5. Both share the stimulus signals.
module tb_apb_mem_bank;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        preset_a, preset_b;
  logic        sel;
  logic        req, we;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;

  apb_mem_bank_if #(.ADDR_W(32), .DATA_W(64)) bus_a ();
  apb_mem_bank_if #(.ADDR_W(32), .DATA_W(64)) bus_b ();

  assign bus_a.mem_req_i   = req & ~sel;
  assign bus_a.mem_addr_i  = addr;
  assign bus_a.mem_we_i    = we;
  assign bus_a.mem_wdata_i = wdata;
  assign bus_a.mem_wstrb_i = wstrb;
  assign bus_b.mem_req_i   = req & sel;
  assign bus_b.mem_addr_i  = addr;
  assign bus_b.mem_we_i    = we;
  assign bus_b.mem_wdata_i = wdata;
  assign bus_b.mem_wstrb_i = wstrb;

  apb_mem_bank #(.BASE_ADDR(32'h1000)) u_dut_a (
    .PCLK(pclk), .PRESET(preset_a), .bus(bus_a)
  );

  apb_mem_bank #(.BASE_ADDR(32'h1000), .RD_LAT(5)) u_dut_b (
    .PCLK(pclk), .PRESET(preset_b), .bus(bus_b)
  );

  logic        obs_valid, obs_busy;
  logic [63:0] obs_rdata;
  assign obs_valid = sel ? bus_b.mem_rdata_valid_o : bus_a.mem_rdata_valid_o;
  assign obs_busy  = sel ? bus_b.busy_o : bus_a.busy_o;
  assign obs_rdata = sel ? bus_b.mem_rdata_o : bus_a.mem_rdata_o;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access. Inputs are scrambled right after the accept edge; the bank
  // must ignore that. lat counts falling edges from accept to the pulse.
  task automatic access(input logic w, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] s, input int hold,
                        output logic [63:0] rd, output int lat,
                        output int extra, output int busy_hold, output logic busy_after);
    logic found;
    @(negedge pclk);
    req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    @(posedge pclk);
    lat = 0; rd = '0; extra = 0; busy_hold = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge pclk);
      found = obs_valid;
      if (found) rd = obs_rdata;
      if (n == 1) begin
        we = ~w; addr = a ^ 32'h18; wdata = ~d; wstrb = ~s;
      end
      if (found) begin
        lat = n;
        break;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge pclk);
      if (obs_valid) extra++;
      if (obs_busy) busy_hold++;
    end
    req = 1'b0;
    @(negedge pclk);
    busy_after = obs_busy;
  endtask

  logic [63:0] rd;
  int          lat, extra, bh, pulses;
  logic        ba;

  initial begin
    preset_a = 1'b1; preset_b = 1'b1; sel = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge pclk);
    chk("rst_valid", {63'd0, obs_valid}, 64'd0);
    chk("rst_rdata", obs_rdata, 64'd0);
    preset_a = 1'b0; preset_b = 1'b0;
    @(negedge pclk);
    chk("rst_busy_a", {63'd0, bus_a.busy_o}, 64'd0);
    chk("rst_busy_b", {63'd0, bus_b.busy_o}, 64'd0);

    // Full write then read back
    access(1'b1, 32'h1008, 64'h1122334455667788, 8'hFF, 0, rd, lat, extra, bh, ba);
    chk("wr_lat", 64'(lat), 64'd1);
    chk("wr_rdata_zero", rd, 64'd0);
    chk("wr_idle_after", {63'd0, ba}, 64'd0);
    access(1'b0, 32'h1008, 64'h0, 8'h00, 0, rd, lat, extra, bh, ba);
    chk("rd_lat", 64'(lat), 64'd2);
    chk("rd_data", rd, 64'h1122334455667788);

    // Partial strobe keeps untouched lanes
    access(1'b1, 32'h1010, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 0, rd, lat, extra, bh, ba);
    access(1'b1, 32'h1010, 64'h0, 8'h0F, 0, rd, lat, extra, bh, ba);
    access(1'b0, 32'h1010, 64'h0, 8'h00, 0, rd, lat, extra, bh, ba);
    chk("strb_data", rd, 64'hAAAAAAAA00000000);

    // Zero strobe: acknowledged, writes nothing
    access(1'b1, 32'h1010, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, rd, lat, extra, bh, ba);
    chk("strb0_lat", 64'(lat), 64'd1);
    access(1'b0, 32'h1010, 64'h0, 8'h00, 0, rd, lat, extra, bh, ba);
    chk("strb0_data", rd, 64'hAAAAAAAA00000000);

    // Request held past the pulse
    access(1'b0, 32'h1010, 64'h0, 8'h00, 3, rd, lat, extra, bh, ba);
    chk("hold_data", rd, 64'hAAAAAAAA00000000);
    chk("hold_pulses", 64'(extra), 64'd0);
    chk("hold_busy", 64'(bh), 64'd3);
    chk("hold_idle_after", {63'd0, ba}, 64'd0);

    // Address wrap onto word 0
    access(1'b1, 32'h0001_1000, 64'h5A, 8'h01, 0, rd, lat, extra, bh, ba);
    access(1'b0, 32'h1000, 64'h0, 8'h00, 0, rd, lat, extra, bh, ba);
    chk("wrap_byte", {56'd0, rd[7:0]}, 64'h5A);

    // Scrambled inputs after accept must not redirect the write
    access(1'b1, 32'h1018, 64'h0F0E0D0C0B0A0908, 8'hFF, 0, rd, lat, extra, bh, ba);
    access(1'b0, 32'h1018, 64'h0, 8'h00, 0, rd, lat, extra, bh, ba);
    chk("capture_data", rd, 64'h0F0E0D0C0B0A0908);
    access(1'b0, 32'h1000, 64'h0, 8'h00, 0, rd, lat, extra, bh, ba);
    chk("capture_no_clobber", {56'd0, rd[7:0]}, 64'h5A);

    // Reset beats a simultaneous request; storage survives reset
    @(negedge pclk);
    preset_a = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h1008;
    wdata = 64'hDEADBEEFDEADBEEF; wstrb = 8'hFF;
    @(negedge pclk);
    preset_a = 1'b0; req = 1'b0;
    chk("rst_prio_busy", {63'd0, bus_a.busy_o}, 64'd0);
    access(1'b0, 32'h1008, 64'h0, 8'h00, 0, rd, lat, extra, bh, ba);
    chk("rst_keep_data", rd, 64'h1122334455667788);

    // Instance B: long read latency
    sel = 1'b1;
    access(1'b1, 32'h1000, 64'h0123456789ABCDEF, 8'hFF, 0, rd, lat, extra, bh, ba);
    chk("b_wr_lat", 64'(lat), 64'd1);
    access(1'b0, 32'h1000, 64'h0, 8'h00, 0, rd, lat, extra, bh, ba);
    chk("b_rd_lat", 64'(lat), 64'd5);
    chk("b_rd_data", rd, 64'h0123456789ABCDEF);

    // Instance B: reset two cycles into a read cancels the response
    @(negedge pclk);
    req = 1'b1; we = 1'b0; addr = 32'h1000;
    @(posedge pclk);
    pulses = 0;
    @(negedge pclk);
    if (obs_valid) pulses++;
    @(negedge pclk);
    if (obs_valid) pulses++;
    preset_b = 1'b1; req = 1'b0;
    @(negedge pclk);
    preset_b = 1'b0;
    chk("b_rst_busy", {63'd0, obs_busy}, 64'd0);
    chk("b_rst_rdata", obs_rdata, 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (obs_valid) pulses++;
    end
    chk("b_rst_no_pulse", 64'(pulses), 64'd0);
    chk("b_rst_idle", {63'd0, obs_busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
